// File: rtl/dest_scoreboard.sv
// Tracks in-flight destination registers through EX..WB and flags RAW hazards for decode.
// Latency: stall/busy are combinational from inputs; a write reaches wb_* DEPTH edges after issue.
// Backpressure: stall holds decode; freeze holds every slot; a hazard drains older slots and inserts a bubble.
module dest_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_wr,
  input  logic [2:0]       id_rd,
  input  logic [2:0]       id_rs,
  input  logic             id_rs_en,
  input  logic [2:0]       id_rt,
  input  logic             id_rt_en,
  input  logic             freeze,
  input  logic             flush,
  output logic             stall,
  output logic [7:0]       busy,
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [CNT_W-1:0] stall_count
);

  // WB is left out of the hazard window when the register file writes before it reads.
  localparam int CHK = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0] slot_v;
  logic [2:0]       slot_rd [DEPTH];
  logic             hazard;
  logic             issue;

  // Pending-register mask over the checked slots.
  always_comb begin
    busy = '0;
    for (int k = 0; k < CHK; k++) begin
      if (slot_v[k]) busy[slot_rd[k]] = 1'b1;
    end
  end

  // RAW hazard on either enabled source; a freeze also stalls decode.
  always_comb begin
    hazard = id_valid && ((id_rs_en && busy[id_rs]) || (id_rt_en && busy[id_rt]));
    stall  = hazard || freeze;
    issue  = id_valid && id_wr && !hazard && !flush && !freeze;
  end

  // Shift pending writes toward WB; slot 0 takes the new write or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v <= '0;
      for (int k = 0; k < DEPTH; k++) slot_rd[k] <= 3'd0;
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_v[k]  <= slot_v[k-1];
        slot_rd[k] <= slot_rd[k-1];
      end
      slot_v[0]  <= issue;
      slot_rd[0] <= issue ? id_rd : 3'd0;
    end
  end

  // Saturating count of cycles lost to hazards (freeze cycles are not counted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hazard && !freeze && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Retiring destination comes straight from the WB slot register.
  always_comb begin
    wb_valid = slot_v[DEPTH-1];
    wb_rd    = slot_rd[DEPTH-1];
  end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Self-checking bench: directed hazard scenarios with a retire-order scoreboard.
// Latency: expects wb_* DEPTH edges after issue, plus any frozen edges.
// Backpressure: drives freeze/flush directly and checks stall response.
module tb_dest_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0, wr = 1'b0, rse = 1'b0, rte = 1'b0, frz = 1'b0, fl = 1'b0;
  logic [2:0]  rd = 3'd0, rs = 3'd0, rt = 3'd0;
  logic        stall, wb_valid;
  logic [7:0]  busy;
  logic [2:0]  wb_rd;
  logic [15:0] stall_count;

  // second instance: WB checked, 4-bit counter, own inputs
  logic        s_v = 1'b0, s_wr = 1'b0, s_rse = 1'b0, s_frz = 1'b0, s_fl = 1'b0;
  logic [2:0]  s_rd = 3'd0, s_rs = 3'd0;
  logic        s_stall, s_wb_valid;
  logic [7:0]  s_busy;
  logic [2:0]  s_wb_rd;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_cnt = 0;
  logic frz_edge = 1'b0;

  typedef struct { int due; logic [2:0] rd; } wb_exp_t;
  wb_exp_t sb_q[$];

  always #5 clk = ~clk;

  dest_scoreboard #(.DEPTH(3), .WB_BYPASS(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(v), .id_wr(wr), .id_rd(rd),
    .id_rs(rs), .id_rs_en(rse), .id_rt(rt), .id_rt_en(rte),
    .freeze(frz), .flush(fl), .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_count(stall_count)
  );

  dest_scoreboard #(.DEPTH(3), .WB_BYPASS(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(s_v), .id_wr(s_wr), .id_rd(s_rd),
    .id_rs(s_rs), .id_rs_en(s_rse), .id_rt(3'd0), .id_rt_en(1'b0),
    .freeze(s_frz), .flush(s_fl), .stall(s_stall), .busy(s_busy),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_in(input logic iv, input logic iwr, input logic [2:0] ird,
                        input logic [2:0] irs, input logic irse,
                        input logic [2:0] irt, input logic irte);
    v = iv; wr = iwr; rd = ird; rs = irs; rse = irse; rt = irt; rte = irte;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // the driven instruction is expected to issue; it retires 3 edges later plus extra frozen edges
  task automatic push_wb(input logic [2:0] r, input int extra);
    wb_exp_t e;
    e.due = cyc + 3 + extra;
    e.rd  = r;
    sb_q.push_back(e);
  endtask

  task automatic mid();   @(negedge clk); endtask
  task automatic next();  @(posedge clk); #1; endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    frz_edge <= frz;
  end

  // Retire monitor: each new WB entry must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_valid && !frz_edge) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        chk("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
        chk("wb_time", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    set_in(1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 3'd3, 1'b1);
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {24'd0, busy}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbrd", {29'd0, wb_rd}, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    chk("rst_scnt", {28'd0, s_stall_count}, 32'd0);
    idle();
    next(); next();
    rst = 1'b0;
    next();

    // back-to-back dependency
    set_in(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0);
    mid(); chk("b2b_issue_stall", {31'd0, stall}, 32'd0); push_wb(3'd3, 0);
    next();
    set_in(1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0);
    mid(); chk("b2b_stall1", {31'd0, stall}, 32'd1); chk("b2b_busy", {24'd0, busy}, 32'h08);
    next();
    mid(); chk("b2b_stall2", {31'd0, stall}, 32'd1);
    next();
    exp_cnt += 2;
    mid(); chk("b2b_stall3", {31'd0, stall}, 32'd0);
    chk("b2b_cnt", {16'd0, stall_count}, exp_cnt);
    chk("b2b_wbv", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wbrd", {29'd0, wb_rd}, 32'd3);
    next(); idle(); next(); next();

    // no dependency
    set_in(1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
    mid(); push_wb(3'd1, 0);
    next();
    set_in(1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("nodep_stall", {31'd0, stall}, 32'd0);
      chk("nodep_busy", {24'd0, busy}, (i < 2) ? 32'h02 : 32'h00);
      next();
    end
    idle(); next(); next();

    // freeze holding a pending write
    set_in(1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0);
    mid(); push_wb(3'd4, 5);
    next();
    set_in(1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 3'd0, 1'b0);
    frz = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("frz_stall", {31'd0, stall}, 32'd1);
      chk("frz_busy", {24'd0, busy}, 32'h10);
      chk("frz_cnt", {16'd0, stall_count}, exp_cnt);
      next();
    end
    frz = 1'b0;
    mid(); chk("unfrz_stall1", {31'd0, stall}, 32'd1); next();
    mid(); chk("unfrz_stall2", {31'd0, stall}, 32'd1); next();
    exp_cnt += 2;
    mid(); chk("unfrz_stall3", {31'd0, stall}, 32'd0);
    chk("unfrz_cnt", {16'd0, stall_count}, exp_cnt);
    next(); idle(); next(); next();

    // flush squashes the decode write
    set_in(1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
    fl = 1'b1;
    mid(); chk("flush_stall", {31'd0, stall}, 32'd0);
    next();
    fl = 1'b0; idle();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("flush_busy6", {31'd0, busy[6]}, 32'd0);
      chk("flush_wbv", {31'd0, wb_valid}, 32'd0);
      next();
    end

    // self-dependency, then the same rd pending twice read via rt
    set_in(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 1'b0);
    mid(); chk("self_stall", {31'd0, stall}, 32'd0); push_wb(3'd2, 0);
    next();
    set_in(1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0);
    mid(); push_wb(3'd2, 0);
    next();
    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1);
    mid(); chk("dup_stall1", {31'd0, stall}, 32'd1); chk("dup_busy", {24'd0, busy}, 32'h04);
    next();
    mid(); chk("dup_stall2", {31'd0, stall}, 32'd1);
    next();
    exp_cnt += 2;
    mid(); chk("dup_stall3", {31'd0, stall}, 32'd0);
    chk("dup_cnt", {16'd0, stall_count}, exp_cnt);
    next(); idle(); next(); next(); next();

    // async reset with three writes in flight
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 1'b1, 3'(i), 3'd0, 1'b0, 3'd0, 1'b0);
      mid(); push_wb(3'(i), 0);
      next();
    end
    set_in(1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0);
    mid(); chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_busy", {24'd0, busy}, 32'h0C);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {24'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("arst_cnt", {16'd0, stall_count}, 32'd0);
    sb_q.delete();
    exp_cnt = 0;
    idle();
    next();
    rst = 1'b0;
    next();

    // saturation: WB checked, one instruction re-issuing and hazarding on itself
    s_v = 1'b1; s_wr = 1'b1; s_rd = 3'd7; s_rs = 3'd7; s_rse = 1'b1;
    begin
      int sexp;
      sexp = 0;
      for (int i = 0; i < 40; i++) begin
        mid();
        chk("sat_stall", {31'd0, s_stall}, (i % 4 != 0) ? 32'd1 : 32'd0);
        chk("sat_cnt", {28'd0, s_stall_count}, sexp);
        if (i >= 3) chk("sat_wbv", {31'd0, s_wb_valid}, (i % 4 == 3) ? 32'd1 : 32'd0);
        if (i % 4 != 0 && sexp < 15) sexp++;
        next();
      end
      mid(); chk("sat_final", {28'd0, s_stall_count}, 32'hF);
    end
    s_v = 1'b0;
    next(); next(); next(); next();
    mid(); chk("sat_hold", {28'd0, s_stall_count}, 32'hF);
    chk("main_cnt_idle", {16'd0, stall_count}, exp_cnt);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
